// File: rtl/siphash_tag_checker.sv
// -----------------------------------------------------------------------------
// siphash_tag_checker
//
// Receive-side SipHash-2-4 MAC verifier. A message stream is absorbed one
// SipHash round per clock under a 128-bit key. The resulting 64-bit tag is
// compared against the expected tag latched at start.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : synchronous active-high reset
//   start      : begin a new check (sampled only in IDLE)
//   key[127:0] : k0 = key[63:0], k1 = key[127:64] (sampled with start)
//   tag_in     : expected tag (sampled with start)
//   msg_valid  : message beat valid
//   msg_ready  : block can accept a beat (WAIT state only)
//   msg_data   : 64-bit little-endian message word
//   msg_last   : this beat is the final block
//   msg_bytes  : valid bytes (0..7) in the last beat
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when match is valid
//   match      : computed tag == tag_in, held until the next result
//   dbg_state  : current FSM state, for observation only
//
// Handshake: a beat transfers on a rising edge where msg_valid && msg_ready.
// The sender must hold the beat stable while msg_ready is low.
// -----------------------------------------------------------------------------

// Combinational SipHash round (SipRound), shared by all round states.
module sip_round (
    input  logic [63:0] v0_i,
    input  logic [63:0] v1_i,
    input  logic [63:0] v2_i,
    input  logic [63:0] v3_i,
    output logic [63:0] v0_o,
    output logic [63:0] v1_o,
    output logic [63:0] v2_o,
    output logic [63:0] v3_o
);
    logic [63:0] a0, a1, a2, a3;
    logic [63:0] b0, b1, b2, b3;

    always_comb begin
        // First half-round
        a0 = v0_i + v1_i;
        a1 = {v1_i[50:0], v1_i[63:51]} ^ a0;   // rotl 13
        a0 = {a0[31:0], a0[63:32]};            // rotl 32
        a2 = v2_i + v3_i;
        a3 = {v3_i[47:0], v3_i[63:48]} ^ a2;   // rotl 16
        // Second half-round
        b0 = a0 + a3;
        b3 = {a3[42:0], a3[63:43]} ^ b0;       // rotl 21
        b2 = a2 + a1;
        b1 = {a1[46:0], a1[63:47]} ^ b2;       // rotl 17
        b2 = {b2[31:0], b2[63:32]};            // rotl 32
    end

    assign v0_o = b0;
    assign v1_o = b1;
    assign v2_o = b2;
    assign v3_o = b3;
endmodule

module siphash_tag_checker (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [63:0]  tag_in,
    input  logic         msg_valid,
    output logic         msg_ready,
    input  logic [63:0]  msg_data,
    input  logic         msg_last,
    input  logic [2:0]   msg_bytes,
    output logic         busy,
    output logic         done,
    output logic         match,
    output logic [2:0]   dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_C1, S_C2, S_F1, S_F2, S_F3, S_F4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] v0_q, v1_q, v2_q, v3_q;
    logic [63:0] v0_d, v1_d, v2_d, v3_d;
    logic [63:0] m_q, m_d;
    logic        last_q, last_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] tag_q, tag_d;
    logic        done_q, done_d;
    logic        match_q, match_d;

    logic [63:0] r0, r1, r2, r3;
    logic [63:0] beat_m;
    logic [63:0] byte_mask;
    logic [7:0]  len_byte;

    sip_round u_round (
        .v0_i(v0_q), .v1_i(v1_q), .v2_i(v2_q), .v3_i(v3_q),
        .v0_o(r0),   .v1_o(r1),   .v2_o(r2),   .v3_o(r3)
    );

    // Last block: keep the low msg_bytes bytes and put L mod 256 in the top
    // byte. {counter, msg_bytes} is 8*words + bytes truncated to 8 bits.
    assign byte_mask = (64'h1 << {msg_bytes, 3'b000}) - 64'h1;
    assign len_byte  = {cnt_q, msg_bytes};
    assign beat_m    = msg_last ? ((msg_data & byte_mask) | {len_byte, 56'h0})
                                : msg_data;

    always_comb begin
        state_d = state_q;
        v0_d    = v0_q;
        v1_d    = v1_q;
        v2_d    = v2_q;
        v3_d    = v3_q;
        m_d     = m_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        done_d  = 1'b0;
        match_d = match_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    v0_d    = key[63:0]   ^ 64'h736f6d6570736575;
                    v1_d    = key[127:64] ^ 64'h646f72616e646f6d;
                    v2_d    = key[63:0]   ^ 64'h6c7967656e657261;
                    v3_d    = key[127:64] ^ 64'h7465646279746573;
                    tag_d   = tag_in;
                    cnt_d   = 5'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (msg_valid) begin
                    m_d    = beat_m;
                    v3_d   = v3_q ^ beat_m;
                    last_d = msg_last;
                    if (!msg_last) begin
                        cnt_d = cnt_q + 5'd1;   // wraps 31->0 on purpose
                    end
                    state_d = S_C1;
                end
            end
            S_C1: begin
                {v0_d, v1_d, v2_d, v3_d} = {r0, r1, r2, r3};
                state_d = S_C2;
            end
            S_C2: begin
                v0_d = r0 ^ m_q;
                v1_d = r1;
                v2_d = last_q ? (r2 ^ 64'hff) : r2;
                v3_d = r3;
                state_d = last_q ? S_F1 : S_WAIT;
            end
            S_F1: begin
                {v0_d, v1_d, v2_d, v3_d} = {r0, r1, r2, r3};
                state_d = S_F2;
            end
            S_F2: begin
                {v0_d, v1_d, v2_d, v3_d} = {r0, r1, r2, r3};
                state_d = S_F3;
            end
            S_F3: begin
                {v0_d, v1_d, v2_d, v3_d} = {r0, r1, r2, r3};
                state_d = S_F4;
            end
            S_F4: begin
                {v0_d, v1_d, v2_d, v3_d} = {r0, r1, r2, r3};
                match_d = ((r0 ^ r1 ^ r2 ^ r3) == tag_q);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            v0_q    <= 64'h0;
            v1_q    <= 64'h0;
            v2_q    <= 64'h0;
            v3_q    <= 64'h0;
            m_q     <= 64'h0;
            last_q  <= 1'b0;
            cnt_q   <= 5'd0;
            tag_q   <= 64'h0;
            done_q  <= 1'b0;
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            v3_q    <= v3_d;
            m_q     <= m_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            done_q  <= done_d;
            match_q <= match_d;
        end
    end

    assign msg_ready = (state_q == S_WAIT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign match     = match_q;
    assign dbg_state = state_q;
endmodule

// File: tb/tb_siphash_tag_checker.sv
module tb_siphash_tag_checker;
  typedef logic [7:0] bq_t[$];

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic [63:0]  tag_in;
  logic         msg_valid;
  logic         msg_ready;
  logic [63:0]  msg_data;
  logic         msg_last;
  logic [2:0]   msg_bytes;
  logic         busy;
  logic         done;
  logic         match;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  siphash_tag_checker dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .tag_in(tag_in),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes), .busy(busy), .done(done),
    .match(match), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [0:0] exp_q[$];
  int hs_q[$];

  localparam logic [127:0] TEST_KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [63:0] mv[4];

  function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic void m_round();
    mv[0] = mv[0] + mv[1]; mv[1] = rotl(mv[1], 13); mv[1] ^= mv[0]; mv[0] = rotl(mv[0], 32);
    mv[2] = mv[2] + mv[3]; mv[3] = rotl(mv[3], 16); mv[3] ^= mv[2];
    mv[0] = mv[0] + mv[3]; mv[3] = rotl(mv[3], 21); mv[3] ^= mv[0];
    mv[2] = mv[2] + mv[1]; mv[1] = rotl(mv[1], 17); mv[1] ^= mv[2]; mv[2] = rotl(mv[2], 32);
  endfunction

  function automatic logic [63:0] ref_tag(input logic [127:0] k, input bq_t msg);
    int n;
    logic [63:0] m;
    n = msg.size();
    mv[0] = k[63:0]   ^ 64'h736f6d6570736575;
    mv[1] = k[127:64] ^ 64'h646f72616e646f6d;
    mv[2] = k[63:0]   ^ 64'h6c7967656e657261;
    mv[3] = k[127:64] ^ 64'h7465646279746573;
    for (int b = 0; b < n / 8; b++) begin
      m = '0;
      for (int j = 0; j < 8; j++) m[8*j +: 8] = msg[8*b + j];
      mv[3] ^= m; m_round(); m_round(); mv[0] ^= m;
    end
    m = 64'(n & 255) << 56;
    for (int j = 0; j < n % 8; j++) m[8*j +: 8] = msg[8*(n/8) + j];
    mv[3] ^= m; m_round(); m_round(); mv[0] ^= m;
    mv[2] ^= 64'hff;
    m_round(); m_round(); m_round(); m_round();
    return mv[0] ^ mv[1] ^ mv[2] ^ mv[3];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; key = '0; tag_in = '0;
    msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0; msg_bytes = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic [2:0] nb);
    int w;
    msg_valid = 1'b1; msg_data = d; msg_last = last; msg_bytes = nb;
    w = 0;
    while (!msg_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    check("beat_accept", msg_ready, 1);
    hs_q.push_back(cyc);
    @(negedge clk);
  endtask

  // Starts at the current negedge; returns at the done negedge (or after abort).
  // inject: 0 none, 1 start pulses during C1 and F2, 2 reset during F3.
  task automatic run_check(input logic [127:0] k, input logic [63:0] tag, input bq_t msg,
                           input bit garbage, input int inject);
    int n, nfull, rem, lat, idx;
    logic [63:0] d;
    logic [0:0] e;
    bit saw;
    start = 1'b1; key = k; tag_in = tag;
    @(negedge clk);
    start = 1'b0;
    key = {$urandom(), $urandom(), $urandom(), $urandom()};
    tag_in = {$urandom(), $urandom()};
    check("ready_after_start", msg_ready, 1);
    hs_q.delete();
    n = msg.size(); nfull = n / 8; rem = n % 8;
    for (int b = 0; b <= nfull; b++) begin
      d = '0;
      for (int j = 0; j < 8; j++) begin
        idx = 8*b + j;
        if (b < nfull || j < rem) d[8*j +: 8] = msg[idx];
        else if (garbage) d[8*j +: 8] = 8'($urandom_range(1, 255));
      end
      send_beat(d, (b == nfull), (b == nfull) ? 3'(rem) : 3'($urandom_range(0, 7)));
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      if (inject == 1 && (lat == 0 || lat == 3)) begin
        start = 1'b1;
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        tag_in = {$urandom(), $urandom()};
      end else begin
        start = 1'b0;
      end
      if (inject == 2 && lat == 4) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_match", match, 0);
        check("abort_ready", msg_ready, 0);
        saw = 0;
        repeat (12) begin
          @(negedge clk);
          if (done) saw = 1;
        end
        check("abort_no_done", saw, 0);
        void'(exp_q.pop_back());
        return;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("done_latency", lat, 6);
    if (done) begin
      e = exp_q.pop_front();
      check("match", match, e);
      check("busy_low_on_done", busy, 0);
    end
  endtask

  // ---------------- stimulus ----------------
  bq_t paper, msg;
  logic [127:0] k;
  logic [63:0] t, rt;
  int bad;

  initial begin
    paper = {};
    for (int i = 0; i < 15; i++) paper.push_back(8'(i));

    do_reset();
    check("reset_ready", msg_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_match", match, 0);

    // 1. empty message
    msg = {};
    exp_q.push_back(1);
    run_check(TEST_KEY, 64'h726fdb47dd0e0e31, msg, 0, 0);
    repeat (2) @(negedge clk);

    // 2. paper vector, clean and with garbage above the valid bytes
    exp_q.push_back(1);
    run_check(TEST_KEY, 64'ha129ca6149be45e5, paper, 0, 0);
    repeat (2) @(negedge clk);
    exp_q.push_back(1);
    run_check(TEST_KEY, 64'ha129ca6149be45e5, paper, 1, 0);
    repeat (2) @(negedge clk);

    // 3. mismatch
    exp_q.push_back(0);
    run_check(TEST_KEY, 64'ha129ca6149be45e4, paper, 0, 0);
    check("mismatch_held", match, 0);
    repeat (2) @(negedge clk);
    check("match_held_idle", match, 0);

    // 4. length wrap: 35 full words, L = 280
    k = {$urandom(), $urandom(), $urandom(), $urandom()};
    msg = {};
    for (int i = 0; i < 280; i++) msg.push_back(8'($urandom_range(0, 255)));
    exp_q.push_back(1);
    run_check(k, ref_tag(k, msg), msg, 1, 0);
    check("wrap_beats", hs_q.size(), 36);
    bad = 0;
    for (int i = 1; i < hs_q.size(); i++) if (hs_q[i] - hs_q[i-1] != 3) bad++;
    check("ready_period", bad, 0);
    repeat (2) @(negedge clk);

    // 5. control corners: valid in IDLE, start ignored while busy
    msg_valid = 1'b1; msg_data = 64'h0706050403020100; msg_last = 1'b0; msg_bytes = 3'd0;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (msg_ready !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("idle_not_ready", bad, 0);
    exp_q.push_back(1);
    run_check(TEST_KEY, 64'ha129ca6149be45e5, paper, 0, 1);
    repeat (2) @(negedge clk);

    // reset during F3, then a fresh check
    exp_q.push_back(1);
    run_check(TEST_KEY, 64'ha129ca6149be45e5, paper, 0, 2);
    exp_q.push_back(1);
    run_check(TEST_KEY, 64'ha129ca6149be45e5, paper, 0, 0);
    repeat (2) @(negedge clk);

    // 6. back-to-back: failing check, then start in its done cycle
    exp_q.push_back(0);
    run_check(TEST_KEY, 64'h0123456789abcdef, paper, 0, 0);
    for (int r = 0; r < 2; r++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      msg = {};
      for (int i = 0; i < $urandom_range(0, 20); i++) msg.push_back(8'($urandom_range(0, 255)));
      exp_q.push_back(1);
      run_check(k, ref_tag(k, msg), msg, 1, 0);
    end
    repeat (2) @(negedge clk);

    // randomized checks against the model
    for (int r = 0; r < 8; r++) begin
      k = {$urandom(), $urandom(), $urandom(), $urandom()};
      msg = {};
      for (int i = 0; i < $urandom_range(0, 40); i++) msg.push_back(8'($urandom_range(0, 255)));
      rt = ref_tag(k, msg);
      t = rt;
      if ($urandom_range(0, 1) == 1) t[$urandom_range(0, 63)] ^= 1'b1;
      exp_q.push_back(t == rt);
      run_check(k, t, msg, $urandom_range(0, 1) == 1, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
